// File: rtl/shared_timer_pkg.sv
// Shared types, defaults and round-robin helper for the interval timer arbiter.
// Optional abort support is selected in the top via TIMER_ARB_ABORT_EN.
package shared_timer_pkg;

    localparam int unsigned DEF_CNT_W   = 5;
    localparam int unsigned DEF_MAX_CNT = (1 << DEF_CNT_W) - 1;
    localparam int unsigned MAX_REQ     = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

    // Winner is the first set bit searching last+1, last+2, ... modulo n.
    function automatic logic [2:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [2:0]         last,
        input int unsigned        n
    );
        logic [2:0]  win;
        logic        found;
        int unsigned idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            if (k <= n) begin
                idx = (32'(last) + k) % n;
                if (!found && req[idx[2:0]]) begin
                    win   = idx[2:0];
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/interval_counter.sv
// Loadable up-counter that saturates by construction: the owner stops
// incrementing once at_max is seen, so the count never wraps.
module interval_counter
    import shared_timer_pkg::*;
#(
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned MAX_CNT = (1 << CNT_W) - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] data_in,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             at_max
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = data_in;
        end else if (inc) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign at_max = (count_q == CNT_W'(MAX_CNT));

endmodule

// File: rtl/shared_interval_timer_arbiter.sv
// Round-robin arbiter sharing one loadable up-counter as an interval timer.
// Defining TIMER_ARB_ABORT_EN adds the abort input and aborted pulse output.
module shared_interval_timer_arbiter
    import shared_timer_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned MAX_CNT = (1 << CNT_W) - 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*CNT_W-1:0]     req_data,
`ifdef TIMER_ARB_ABORT_EN
    input  logic                       abort,
    output logic [N_REQ-1:0]           aborted,
`endif
    output logic [N_REQ-1:0]           gnt,
    output logic [N_REQ-1:0]           done,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic [CNT_W-1:0]           count
);

    localparam int unsigned OW = $clog2(N_REQ);
    localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    state_e           state_q;
    logic [N_REQ-1:0] gnt_q;
    logic [N_REQ-1:0] done_q;
    logic             busy_q;
    logic [OW-1:0]    owner_q;
    logic [OW-1:0]    last_q;

    logic [OW-1:0]    win_d;
    logic [CNT_W-1:0] start_d;
    logic             load;
    logic             inc;
    logic             at_max;
    logic             abort_hit;
    logic [CNT_W-1:0] cnt;

`ifdef TIMER_ARB_ABORT_EN
    logic [N_REQ-1:0] aborted_q;
    assign abort_hit = abort;
    assign aborted   = aborted_q;
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        win_d   = OW'(rr_pick(8'(req), 3'(last_q), N_REQ));
        start_d = req_data[win_d*CNT_W +: CNT_W];
    end

    // Abort freezes the count just like the terminal cycle does.
    always_comb begin
        load = (state_q == IDLE) && (|req);
        inc  = (state_q == COUNT) && !at_max && !abort_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            done_q    <= '0;
            busy_q    <= 1'b0;
            owner_q   <= '0;
            last_q    <= OW'(N_REQ - 1);
`ifdef TIMER_ARB_ABORT_EN
            aborted_q <= '0;
`endif
        end else begin
            gnt_q     <= '0;
            done_q    <= '0;
`ifdef TIMER_ARB_ABORT_EN
            aborted_q <= '0;
`endif
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        owner_q <= win_d;
                        last_q  <= win_d;
                        gnt_q   <= ONE << win_d;
                        busy_q  <= 1'b1;
                        state_q <= COUNT;
                    end
                end
                COUNT: begin
                    if (abort_hit) begin
`ifdef TIMER_ARB_ABORT_EN
                        aborted_q <= ONE << owner_q;
`endif
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (at_max) begin
                        done_q  <= ONE << owner_q;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    interval_counter #(
        .CNT_W   (CNT_W),
        .MAX_CNT (MAX_CNT)
    ) u_counter (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .data_in (start_d),
        .inc     (inc),
        .count   (cnt),
        .at_max  (at_max)
    );

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign owner = owner_q;
    assign count = cnt;

endmodule

// File: tb/tb_shared_interval_timer_arbiter.sv
// Bench for shared_interval_timer_arbiter: interval-level reference model plus
// directed literal checks; abort scenario included when TIMER_ARB_ABORT_EN is set.
module tb_shared_interval_timer_arbiter;

    localparam int N  = 4;
    localparam int W  = 5;
    localparam int OW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic           busy;
    logic [OW-1:0]  owner;
    logic [W-1:0]   count;
`ifdef TIMER_ARB_ABORT_EN
    logic           abort = 1'b0;
    logic [N-1:0]   aborted;
`endif

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    shared_interval_timer_arbiter #(
        .N_REQ (N),
        .CNT_W (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
`ifdef TIMER_ARB_ABORT_EN
        .abort    (abort),
        .aborted  (aborted),
`endif
        .gnt      (gnt),
        .done     (done),
        .busy     (busy),
        .owner    (owner),
        .count    (count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Interval-level model: count is start plus elapsed cycles since grant,
    // and the interval lasts (32 - start) cycles.
    bit           m_valid = 1'b0;
    bit           m_busy;
    int           m_owner, m_last, m_start, m_el, m_count, m_idx;
    bit           m_found;
    logic [N-1:0] m_gnt, m_done, m_ab;

    always @(posedge clk) begin
        m_valid = 1'b1;
        m_gnt   = '0;
        m_done  = '0;
        m_ab    = '0;
        if (rst) begin
            m_busy  = 1'b0;
            m_owner = 0;
            m_last  = N - 1;
            m_count = 0;
        end else if (!m_busy) begin
            if (req != '0) begin
                m_found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    m_idx = (m_last + k) % N;
                    if (!m_found && req[m_idx]) begin
                        m_found = 1'b1;
                        m_owner = m_idx;
                    end
                end
                m_last  = m_owner;
                m_start = int'(req_data[m_owner*W +: W]);
                m_el    = 0;
                m_count = m_start;
                m_busy  = 1'b1;
                m_gnt[m_owner] = 1'b1;
            end
        end else begin
            m_el++;
`ifdef TIMER_ARB_ABORT_EN
            if (abort) begin
                m_ab[m_owner] = 1'b1;
                m_busy = 1'b0;
            end else
`endif
            if (m_el == 32 - m_start) begin
                m_done[m_owner] = 1'b1;
                m_busy = 1'b0;
            end else begin
                m_count = m_start + m_el;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_gnt",   32'(gnt),   32'(m_gnt));
            chk("model_done",  32'(done),  32'(m_done));
            chk("model_busy",  32'(busy),  32'(m_busy));
            chk("model_owner", 32'(owner), 32'(m_owner));
            chk("model_count", 32'(count), 32'(m_count));
`ifdef TIMER_ARB_ABORT_EN
            chk("model_aborted", 32'(aborted), 32'(m_ab));
`endif
        end
    end

    task automatic wait_gnt(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (gnt != '0) seen = 1'b1;
        end
        if (!seen) chk({name, "_gnt_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_count(input string name, input int v);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if (int'(count) == v) seen = 1'b1;
        end
        if (!seen) chk({name, "_count_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int order[5];
        int ng;

        // Reset with every request asserted
        rst = 1'b1;
        req = 4'b1111;
        req_data = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_gnt",   32'(gnt),   32'd0);
            chk("rst_done",  32'(done),  32'd0);
            chk("rst_busy",  32'(busy),  32'd0);
            chk("rst_count", 32'(count), 32'd0);
        end

        // Single request, start 28
        rst = 1'b0;
        req = 4'b0100;
        req_data = 20'(28) << 10;
        wait_gnt("single");
        chk("single_gnt",   32'(gnt),   32'h4);
        chk("single_count", 32'(count), 32'd28);
        req = '0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk("single_count_run", 32'(count), 32'(28 + i));
            chk("single_no_done",   32'(done),  32'd0);
        end
        @(negedge clk);
        chk("single_done", 32'(done), 32'h4);
        chk("single_idle", 32'(busy), 32'd0);

        // Fairness with all start values at terminal count
        rst = 1'b1;
        req = 4'b1111;
        req_data = '1;
        @(negedge clk);
        rst = 1'b0;
        ng = 0;
        for (int i = 0; i < 5; i++) order[i] = -1;
        for (int c = 0; c < 30 && ng < 5; c++) begin
            @(negedge clk);
            if (gnt != '0) begin
                for (int b = 0; b < N; b++) if (gnt[b]) order[ng] = b;
                ng++;
            end
        end
        req = '0;
        chk("rr_order0", 32'(order[0]), 32'd0);
        chk("rr_order1", 32'(order[1]), 32'd1);
        chk("rr_order2", 32'(order[2]), 32'd2);
        chk("rr_order3", 32'(order[3]), 32'd3);
        chk("rr_order4", 32'(order[4]), 32'd0);
        repeat (3) @(negedge clk);

        // Start value 0: full 32-cycle interval, no wrap
        req = 4'b0001;
        req_data = '0;
        wait_gnt("zero");
        chk("zero_gnt",   32'(gnt),   32'h1);
        chk("zero_count", 32'(count), 32'd0);
        req = '0;
        for (int i = 1; i <= 31; i++) begin
            @(negedge clk);
            chk("zero_count_run", 32'(count), 32'(i));
            chk("zero_busy",      32'(busy),  32'd1);
        end
        @(negedge clk);
        chk("zero_done",       32'(done),  32'h1);
        chk("zero_count_held", 32'(count), 32'd31);
        @(negedge clk);
        chk("zero_no_wrap", 32'(count), 32'd31);

        // Reset mid-interval
        req = 4'b0001;
        req_data = '0;
        wait_gnt("midrst");
        req = '0;
        wait_count("midrst", 17);
        rst = 1'b1;
        req = 4'b1000;
        req_data = 20'(30) << 15;
        @(negedge clk);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_busy",  32'(busy),  32'd0);
        chk("midrst_done",  32'(done),  32'd0);
        rst = 1'b0;
        wait_gnt("post_rst");
        chk("post_rst_gnt",   32'(gnt),   32'h8);
        chk("post_rst_count", 32'(count), 32'd30);
        req = '0;
        repeat (3) @(negedge clk);

`ifdef TIMER_ARB_ABORT_EN
        // Abort owner 1 at count 20 while requester 0 waits
        req = 4'b0010;
        req_data = (20'(10) << 5) | 20'(31);
        wait_gnt("abort");
        chk("abort_gnt", 32'(gnt), 32'h2);
        req = 4'b0001;
        wait_count("abort", 20);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_pulse", 32'(aborted), 32'h2);
        chk("abort_done",  32'(done),    32'd0);
        chk("abort_busy",  32'(busy),    32'd0);
        chk("abort_count", 32'(count),   32'd20);
        @(negedge clk);
        chk("abort_next_gnt", 32'(gnt), 32'h1);
        req = '0;
        repeat (3) @(negedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
